// File: rtl/morse_pkg.sv
// Shared definitions for the Morse transmitter: character codes, element
// patterns and controller states.
package morse_pkg;

  localparam int NUM_CODES = 36;

  localparam logic [5:0] CODE_0 = 6'd0;
  localparam logic [5:0] CODE_9 = 6'd9;
  localparam logic [5:0] CODE_A = 6'd10;
  localparam logic [5:0] CODE_B = 6'd11;
  localparam logic [5:0] CODE_E = 6'd14;
  localparam logic [5:0] CODE_T = 6'd29;
  localparam logic [5:0] CODE_Z = 6'd35;

  // bits are left-aligned: bit 4 is the first element, 1 = dash, 0 = dot
  typedef struct packed {
    logic [2:0] len;
    logic [4:0] bits;
  } morse_pat_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MARK,
    ST_GAP,
    ST_CHAR_GAP
  } morse_state_t;

  function automatic morse_pat_t morse_pat(input logic [2:0] len, input logic [4:0] bits);
    morse_pat_t p;
    p.len  = len;
    p.bits = bits;
    return p;
  endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational code -> Morse element pattern lookup for digits and letters.
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0]  code,
  output logic        valid,
  output morse_pat_t  pat
);

  always_comb begin
    valid = (code < 6'(NUM_CODES));
    pat   = morse_pat(3'd0, 5'b00000);
    case (code)
      6'd0:  pat = morse_pat(3'd5, 5'b11111);
      6'd1:  pat = morse_pat(3'd5, 5'b01111);
      6'd2:  pat = morse_pat(3'd5, 5'b00111);
      6'd3:  pat = morse_pat(3'd5, 5'b00011);
      6'd4:  pat = morse_pat(3'd5, 5'b00001);
      6'd5:  pat = morse_pat(3'd5, 5'b00000);
      6'd6:  pat = morse_pat(3'd5, 5'b10000);
      6'd7:  pat = morse_pat(3'd5, 5'b11000);
      6'd8:  pat = morse_pat(3'd5, 5'b11100);
      6'd9:  pat = morse_pat(3'd5, 5'b11110);
      6'd10: pat = morse_pat(3'd2, 5'b01000); // A
      6'd11: pat = morse_pat(3'd4, 5'b10000);
      6'd12: pat = morse_pat(3'd4, 5'b10100);
      6'd13: pat = morse_pat(3'd3, 5'b10000);
      6'd14: pat = morse_pat(3'd1, 5'b00000);
      6'd15: pat = morse_pat(3'd4, 5'b00100);
      6'd16: pat = morse_pat(3'd3, 5'b11000);
      6'd17: pat = morse_pat(3'd4, 5'b00000);
      6'd18: pat = morse_pat(3'd2, 5'b00000);
      6'd19: pat = morse_pat(3'd4, 5'b01110);
      6'd20: pat = morse_pat(3'd3, 5'b10100);
      6'd21: pat = morse_pat(3'd4, 5'b01000);
      6'd22: pat = morse_pat(3'd2, 5'b11000);
      6'd23: pat = morse_pat(3'd2, 5'b10000);
      6'd24: pat = morse_pat(3'd3, 5'b11100);
      6'd25: pat = morse_pat(3'd4, 5'b01100);
      6'd26: pat = morse_pat(3'd4, 5'b11010);
      6'd27: pat = morse_pat(3'd3, 5'b01000);
      6'd28: pat = morse_pat(3'd3, 5'b00000);
      6'd29: pat = morse_pat(3'd1, 5'b10000);
      6'd30: pat = morse_pat(3'd3, 5'b00100);
      6'd31: pat = morse_pat(3'd4, 5'b00010);
      6'd32: pat = morse_pat(3'd3, 5'b01100);
      6'd33: pat = morse_pat(3'd4, 5'b10010);
      6'd34: pat = morse_pat(3'd4, 5'b10110);
      6'd35: pat = morse_pat(3'd4, 5'b11000); // Z
      default: pat = morse_pat(3'd0, 5'b00000);
    endcase
  end

endmodule

// File: rtl/morse_tx.sv
// Single-character Morse keyer: looks up the element pattern on accept and
// times marks and gaps in units of UNIT_CYCLES clocks.
module morse_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic [5:0] code,
  output logic       ready,
  output logic       key,
  output logic       dot,
  output logic       dash,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(3 * UNIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_1U = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_3U = CW'(3 * UNIT_CYCLES - 1);

  morse_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bits_q, bits_d;
  logic [2:0]    len_q, len_d;
  logic ready_q, ready_d, key_q, key_d, dot_q, dot_d;
  logic dash_q, dash_d, done_q, done_d, err_q, err_d;

  logic       rom_valid;
  morse_pat_t rom_pat;
  logic       accept;
  logic       next_dash;
  logic       mark_entry;

  morse_rom u_rom (
    .code  (code),
    .valid (rom_valid),
    .pat   (rom_pat)
  );

  assign accept = (state_q == ST_IDLE) && start;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      len_q   <= '0;
      ready_q <= 1'b1;
      key_q   <= 1'b0;
      dot_q   <= 1'b0;
      dash_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      len_q   <= len_d;
      ready_q <= ready_d;
      key_q   <= key_d;
      dot_q   <= dot_d;
      dash_q  <= dash_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && rom_valid) begin
          state_d = ST_MARK;
          bits_d  = rom_pat.bits;
          len_d   = rom_pat.len;
          cnt_d   = rom_pat.bits[4] ? CNT_3U : CNT_1U;
        end
      end
      ST_MARK: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (len_q == 3'd1) begin
          state_d = ST_CHAR_GAP;
          cnt_d   = CNT_3U;
        end else begin
          state_d = ST_GAP;
          cnt_d   = CNT_1U;
          bits_d  = {bits_q[3:0], 1'b0};
          len_d   = len_q - 3'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_MARK;
          cnt_d   = bits_q[4] ? CNT_3U : CNT_1U;
        end
      end
      ST_CHAR_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_IDLE;
          bits_d  = '0;
          len_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered: each *_d describes the cycle after this edge.
  always_comb begin
    next_dash  = (state_q == ST_IDLE) ? rom_pat.bits[4] : bits_q[4];
    mark_entry = (state_d == ST_MARK) && (state_q != ST_MARK);
    ready_d    = (state_d == ST_IDLE);
    key_d      = (state_d == ST_MARK);
    dot_d      = mark_entry && !next_dash;
    dash_d     = mark_entry && next_dash;
    done_d     = (state_q == ST_CHAR_GAP) && (cnt_q == CW'(1));
    err_d      = accept && !rom_valid;
  end

  assign ready = ready_q;
  assign key   = key_q;
  assign dot   = dot_q;
  assign dash  = dash_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_morse_tx.sv
// Directed bench for morse_tx: table of characters on U=2 and U=1 instances
// plus hand-written sequences for reset, busy-start and back-to-back cases.
module tb_morse_tx;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       start_a, start_b;
  logic [5:0] code_a, code_b;
  logic       ready_a, key_a, dot_a, dash_a, done_a, err_a;
  logic       ready_b, key_b, dot_b, dash_b, done_b, err_b;
  logic       sel;
  logic       o_ready, o_key, o_dot, o_dash, o_done, o_err;

  int total = 0;
  int bad   = 0;

  logic cap_key[64], cap_dot[64], cap_dash[64], cap_done[64], cap_err[64], cap_rdy[64];

  always #5 Clock = ~Clock;

  morse_tx #(.UNIT_CYCLES(2)) dut_u2 (
    .Clock(Clock), .Reset(Reset), .start(start_a), .code(code_a),
    .ready(ready_a), .key(key_a), .dot(dot_a), .dash(dash_a), .done(done_a), .err(err_a)
  );

  morse_tx #(.UNIT_CYCLES(1)) dut_u1 (
    .Clock(Clock), .Reset(Reset), .start(start_b), .code(code_b),
    .ready(ready_b), .key(key_b), .dot(dot_b), .dash(dash_b), .done(done_b), .err(err_b)
  );

  always_comb begin
    o_ready = sel ? ready_b : ready_a;
    o_key   = sel ? key_b   : key_a;
    o_dot   = sel ? dot_b   : dot_a;
    o_dash  = sel ? dash_b  : dash_a;
    o_done  = sel ? done_b  : done_a;
    o_err   = sel ? err_b   : err_a;
  end

  typedef struct {
    logic       s;       // 0 = U2 instance, 1 = U1 instance
    logic [5:0] c;
    int         errs, dots, dashes, keyhi, rdy, done_at;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input logic s, input logic v, input logic [5:0] c);
    if (s) begin start_b = v; code_b = c; end
    else   begin start_a = v; code_a = c; end
  endtask

  // Pulse start for one edge, then capture cycles 1.. until ready returns.
  task automatic send_cap(input logic s, input logic [5:0] c, output int rc);
    for (int k = 0; k < 64; k++) begin
      cap_key[k] = 0; cap_dot[k] = 0; cap_dash[k] = 0;
      cap_done[k] = 0; cap_err[k] = 0; cap_rdy[k] = 0;
    end
    sel = s;
    @(negedge Clock);
    set_start(s, 1'b1, c);
    @(posedge Clock);
    rc = 0;
    for (int k = 1; k < 64; k++) begin
      @(negedge Clock);
      if (k == 1) set_start(s, 1'b0, 6'd5);
      cap_key[k] = o_key; cap_dot[k] = o_dot; cap_dash[k] = o_dash;
      cap_done[k] = o_done; cap_err[k] = o_err; cap_rdy[k] = o_ready;
      if (o_ready) begin
        rc = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, nd, nk, ndot, ndash, nerr, dat, ndone;
    vt[0]  = '{1'b0, 6'd14, 0, 1, 0,  2,  9,  8};  // E  U2
    vt[1]  = '{1'b0, 6'd29, 0, 0, 1,  6, 13, 12};  // T  U2
    vt[2]  = '{1'b1, 6'd0,  0, 0, 5, 15, 23, 22};  // 0  U1
    vt[3]  = '{1'b0, 6'd11, 0, 3, 1, 12, 25, 24};  // B  U2
    vt[4]  = '{1'b1, 6'd10, 0, 1, 1,  4,  9,  8};  // A  U1
    vt[5]  = '{1'b0, 6'd26, 0, 1, 3, 20, 33, 32};  // Q  U2
    vt[6]  = '{1'b1, 6'd5,  0, 5, 0,  5, 13, 12};  // 5  U1
    vt[7]  = '{1'b0, 6'd35, 0, 2, 2, 16, 29, 28};  // Z  U2
    vt[8]  = '{1'b0, 6'd36, 1, 0, 0,  0,  1,  0};  // invalid
    vt[9]  = '{1'b1, 6'd63, 1, 0, 0,  0,  1,  0};  // invalid
    vt[10] = '{1'b1, 6'd34, 0, 1, 3, 10, 17, 16};  // Y  U1

    sel = 1'b0;
    Reset = 1'b1;
    start_a = 1'b0; start_b = 1'b0; code_a = '0; code_b = '0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("rst_ready_a", ready_a, 1);
    chk("rst_ready_b", ready_b, 1);
    chk("rst_outs_a", {key_a, dot_a, dash_a, done_a, err_a}, 0);
    chk("rst_outs_b", {key_b, dot_b, dash_b, done_b, err_b}, 0);
    Reset = 1'b0;

    foreach (vt[i]) begin
      send_cap(vt[i].s, vt[i].c, rc);
      nk = 0; ndot = 0; ndash = 0; nerr = 0; dat = 0; ndone = 0;
      for (int k = 1; k < 64; k++) begin
        nk += int'(cap_key[k]); ndot += int'(cap_dot[k]); ndash += int'(cap_dash[k]);
        nerr += int'(cap_err[k]); ndone += int'(cap_done[k]);
        if (cap_done[k] && dat == 0) dat = k;
      end
      chk($sformatf("v%0d_err", i), nerr, vt[i].errs);
      chk($sformatf("v%0d_dots", i), ndot, vt[i].dots);
      chk($sformatf("v%0d_dashes", i), ndash, vt[i].dashes);
      chk($sformatf("v%0d_keyhi", i), nk, vt[i].keyhi);
      chk($sformatf("v%0d_ready_cycle", i), rc, vt[i].rdy);
      chk($sformatf("v%0d_done_cycle", i), dat, vt[i].done_at);
      chk($sformatf("v%0d_done_count", i), ndone, (vt[i].errs != 0) ? 0 : 1);
      // exact waveform checks for the characters called out by name
      if (i == 0) begin
        for (int k = 1; k <= 9; k++) begin
          chk($sformatf("E_key_c%0d", k), cap_key[k], (k <= 2) ? 1 : 0);
          chk($sformatf("E_dot_c%0d", k), cap_dot[k], (k == 1) ? 1 : 0);
        end
      end
      if (i == 1) chk("T_dash_c1", cap_dash[1], 1);
      if (i == 2) begin
        for (int k = 1; k <= 22; k++) begin
          chk($sformatf("0_dash_c%0d", k), cap_dash[k],
              (k == 1 || k == 5 || k == 9 || k == 13 || k == 17) ? 1 : 0);
          chk($sformatf("0_key_c%0d", k), cap_key[k], (((k - 1) % 4) < 3 && k < 20) ? 1 : 0);
        end
      end
      if (i == 8) chk("inv_key_ready", {cap_key[1], cap_rdy[1]}, 2'b01);
    end

    // Reset during the second element of 'B' on U=1
    sel = 1'b1;
    @(negedge Clock);
    start_b = 1'b1; code_b = 6'd11;
    @(posedge Clock);
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clock);
      if (k == 1) start_b = 1'b0;
    end
    chk("rstmid_dot_c5", {key_b, dot_b}, 2'b11);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("rstmid_key", key_b, 0);
    chk("rstmid_ready", ready_b, 1);
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge Clock);
      nd += int'(done_b) + int'(key_b);
    end
    chk("rstmid_quiet", nd, 0);
    send_cap(1'b1, 6'd29, rc);
    chk("after_rst_T_ready_cycle", rc, 7);
    chk("after_rst_T_dash", cap_dash[1], 1);
    chk("after_rst_T_done", cap_done[6], 1);

    // Reset wins over start in the same cycle
    @(negedge Clock);
    start_b = 1'b1; code_b = 6'd29; Reset = 1'b1;
    @(negedge Clock);
    start_b = 1'b0; Reset = 1'b0;
    chk("rst_over_start", {ready_b, key_b, dash_b}, 3'b100);

    // start pulse while busy with 'E' on U=2 is ignored
    sel = 1'b0;
    @(negedge Clock);
    start_a = 1'b1; code_a = 6'd14;
    @(posedge Clock);
    nk = 0; ndot = 0; ndone = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clock);
      if (k == 1 || k == 4) start_a = 1'b0;
      if (k == 3) start_a = 1'b1;
      nk += int'(key_a); ndot += int'(dot_a); ndone += int'(done_a);
      if (k >= 9) chk($sformatf("busy_ign_idle_c%0d", k), {ready_a, key_a}, 2'b10);
    end
    chk("busy_ign_keyhi", nk, 2);
    chk("busy_ign_dots", ndot, 1);
    chk("busy_ign_done", ndone, 1);

    // start held across two 'E' characters
    @(negedge Clock);
    start_a = 1'b1; code_a = 6'd14;
    @(posedge Clock);
    ndone = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge Clock);
      cap_key[k] = key_a; cap_dot[k] = dot_a; cap_done[k] = done_a; cap_rdy[k] = ready_a;
      ndone += int'(done_a);
      if (ndone == 2) start_a = 1'b0;
    end
    chk("b2b_done_c8", cap_done[8], 1);
    chk("b2b_ready_c9", {cap_rdy[9], cap_key[9]}, 2'b10);
    chk("b2b_key_c10", {cap_key[10], cap_dot[10], cap_rdy[10]}, 3'b110);
    chk("b2b_key_c12", cap_key[12], 0);
    chk("b2b_done_c17", cap_done[17], 1);
    chk("b2b_ready_c18", cap_rdy[18], 1);
    chk("b2b_done_count", ndone, 2);
    chk("b2b_no_third", cap_key[20], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morse_tx.md
MORSE_TX -- requirements
Module: morse_tx

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 4, meaning clock cycles per Morse time unit (legal range 1..255).
REQ-002 SHALL have port Clock  input  1  rising-edge clock.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to send one character; sampled only while ready=1.
REQ-005 SHALL have port code  input  6  character code: 0..9 = digits '0'..'9', 10..35 = 'A'..'Z'; 36..63 are invalid.
REQ-006 SHALL have port ready  output  1  block idle and able to accept start.
REQ-007 SHALL have port key  output  1  keyed carrier: 1 during a mark (dot/dash), 0 during gaps and idle.
REQ-008 SHALL have port dot  output  1  one-cycle strobe on the first cycle of each dot mark.
REQ-009 SHALL have port dash  output  1  one-cycle strobe on the first cycle of each dash mark.
REQ-010 SHALL have port done  output  1  one-cycle strobe on the last cycle of a character's trailing gap.
REQ-011 SHALL have port err  output  1  one-cycle strobe when start is accepted with an invalid code.

Function
REQ-012 SHALL accept a request when start=1 and ready=1 at a rising Clock edge ("accept edge"); code is latched there and may change afterwards.
REQ-013 SHALL ignore start while ready=0; requests are not queued.
REQ-014 SHALL map each valid code to the standard International Morse element sequence (1..5 elements, first element first), e.g. 14='E' ".", 29='T' "-", 0='0' "-----", 11='B' "-...".
REQ-015 SHALL implement FSM states IDLE, MARK, GAP, CHAR_GAP; all outputs registered.
REQ-016 IDLE: ready=1, key=0; on valid accept -> MARK with first element; on invalid accept -> stay IDLE, err=1 for the cycle after the accept edge, no other output changes.
REQ-017 MARK: key=1 for exactly UNIT_CYCLES cycles (dot) or 3*UNIT_CYCLES cycles (dash), beginning the cycle after the accept edge or after the preceding gap; dot/dash strobe on its first cycle only.
REQ-018 MARK end: elements remaining -> GAP; last element -> CHAR_GAP.
REQ-019 GAP: key=0 for exactly UNIT_CYCLES cycles, then MARK with next element.
REQ-020 CHAR_GAP: key=0 for exactly 3*UNIT_CYCLES cycles, done=1 on its last cycle, then IDLE.
REQ-021 ready SHALL be 0 from the cycle after a valid accept edge through the last CHAR_GAP cycle, and 1 in the following cycle.
REQ-022 Busy duration SHALL be U*(sum of mark units + (n-1) + 3) cycles, U=UNIT_CYCLES, n=element count, dot=1 unit, dash=3 units.
REQ-023 The unit counter SHALL be wide enough for 3*UNIT_CYCLES and SHALL not wrap within any interval.
REQ-024 Back-to-back: start held high SHALL be re-accepted on the first ready=1 cycle, giving exactly 3*U idle key between characters plus the one IDLE cycle.

Reset
REQ-025 Reset=1 at a rising edge SHALL force IDLE: ready=1, key=0, dot=0, dash=0, done=0, err=0, counter and latched pattern cleared.
REQ-026 Reset SHALL override start in the same cycle and SHALL abort a character mid-mark or mid-gap with no done strobe.

Structure
REQ-027 Package morse_pkg SHALL hold the 6-bit code constants shared with the decoder, the element-pattern type (length 3 bits, dot/dash bits 5), the FSM state enum, and the NUM_CODES=36 constant.
REQ-028 Sub-module morse_rom (combinational code -> {valid, length, pattern}) SHALL implement REQ-014; morse_tx holds the FSM, unit counter and element shift register.

Verification
REQ-029 U=2, start with code=14 ('E') -> key=1 cycles 1..2 after accept, dot strobe cycle 1, key=0 cycles 3..8, done cycle 8, ready=1 cycle 9.
REQ-030 U=2, code=29 ('T') -> key=1 cycles 1..6, dash strobe cycle 1, done cycle 12, ready=1 cycle 13.
REQ-031 U=1, code=0 ('0') -> five dash strobes at cycles 1,5,9,13,17, key=1 3 cycles each, done cycle 22.
REQ-032 code=36 with start -> err=1 cycle 1, key stays 0, ready stays 1.
REQ-033 U=1, code=11 ('B') accepted, Reset asserted during the second element -> next cycle key=0, ready=1, no done; new start with code=29 transmits normally.
REQ-034 Start pulsed while busy with 'E' -> ignored; start held across two 'E' characters -> second accepted on first ready cycle, two done strobes.
